// File: rtl/bitonic_sort_dec_4_seq.sv
`default_nettype none
// ============================================================================
// Module   : bitonic_sort_dec_4_seq
// Brief    : Sorts batches of 4 unsigned words into descending order with a
//            3-stage bitonic network, one stage per clock. Optional macro
//            SORT_INDEX_OUT_EN adds y_idx (arrival position of each output).
// Revision : 1.0 - initial release
// ============================================================================
module bitonic_sort_dec_4_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [W-1:0] x_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [W-1:0] y_data,
    output logic         y_last,
    output logic         busy
`ifdef SORT_INDEX_OUT_EN
    ,
    output logic [1:0]   y_idx
`endif
);

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t       r_state;
    logic [1:0]   r_cnt;
    logic [W-1:0] r_d [4];
    logic [W-1:0] w_d [4];
    logic [1:0]   w_a [2];
    logic [1:0]   w_b [2];
    logic         w_desc [2];
    logic         w_swap [2];
`ifdef SORT_INDEX_OUT_EN
    logic [1:0]   r_t [4];
    logic [1:0]   w_t [4];
`endif

    // Two disjoint compare-exchange pairs per stage; S1 builds the bitonic
    // sequence (second pair ascending), S2/S3 merge it descending.
    always_comb begin
        w_a[0]    = 2'd0;
        w_b[0]    = 2'd1;
        w_a[1]    = 2'd2;
        w_b[1]    = 2'd3;
        w_desc[0] = 1'b1;
        w_desc[1] = 1'b1;
        if (r_state == S1) begin
            w_desc[1] = 1'b0;
        end
        if (r_state == S2) begin
            w_b[0] = 2'd2;
            w_a[1] = 2'd1;
        end
        w_d = r_d;
`ifdef SORT_INDEX_OUT_EN
        w_t = r_t;
`endif
        for (int p = 0; p < 2; p++) begin
            // Strict comparisons: equal words never move.
            w_swap[p] = w_desc[p] ? (r_d[w_a[p]] < r_d[w_b[p]])
                                  : (r_d[w_a[p]] > r_d[w_b[p]]);
            if (w_swap[p]) begin
                w_d[w_a[p]] = r_d[w_b[p]];
                w_d[w_b[p]] = r_d[w_a[p]];
`ifdef SORT_INDEX_OUT_EN
                w_t[w_a[p]] = r_t[w_b[p]];
                w_t[w_b[p]] = r_t[w_a[p]];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_d[i] <= '0;
`ifdef SORT_INDEX_OUT_EN
                r_t[i] <= 2'd0;
`endif
            end
        end else begin
            case (r_state)
                FILL: begin
                    if (x_valid) begin
                        r_d[r_cnt] <= x_data;
`ifdef SORT_INDEX_OUT_EN
                        r_t[r_cnt] <= r_cnt;
`endif
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S1;
                        end
                    end
                end
                S1, S2, S3: begin
                    r_d <= w_d;
`ifdef SORT_INDEX_OUT_EN
                    r_t <= w_t;
`endif
                    r_state <= (r_state == S1) ? S2 : (r_state == S2) ? S3 : DRAIN;
                end
                DRAIN: begin
                    if (y_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= FILL;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state so reset acts immediately.
    assign x_ready = (r_state == FILL);
    assign y_valid = (r_state == DRAIN);
    assign y_data  = y_valid ? r_d[r_cnt] : '0;
    assign y_last  = y_valid && (r_cnt == 2'd3);
    assign busy    = !((r_state == FILL) && (r_cnt == 2'd0));
`ifdef SORT_INDEX_OUT_EN
    assign y_idx   = y_valid ? r_t[r_cnt] : 2'd0;
`endif

endmodule
`default_nettype wire
